// File: rtl/hpi_pkg.sv
// Shared constants for the HPI responder: register indices on the 2-bit bus
// address and bit positions inside the STATUS register.
package hpi_pkg;

  // Register select values on hpi_address
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // STATUS bit positions
  localparam int ST_OUT_FULL  = 0;
  localparam int ST_HOST_PEND = 1;
  localparam int ST_OVR       = 2;
  localparam int ST_ERR       = 3;

  // Pack the STATUS read word from its four flag sources.
  function automatic logic [15:0] status_word(input logic err, input logic ovr,
                                              input logic host_pend, input logic out_full);
    logic [15:0] s;
    s               = '0;
    s[ST_ERR]       = err;
    s[ST_OVR]       = ovr;
    s[ST_HOST_PEND] = host_pend;
    s[ST_OUT_FULL]  = out_full;
    return s;
  endfunction

endpackage

// File: rtl/hpi_sp_ram.sv
// Single-port synchronous word RAM, DEPTH x 16, registered read.
// Ports:
//   clk   - clock
//   en    - access enable; nothing happens when low, rdata holds
//   we    - write when high (with en), otherwise read
//   addr  - word index
//   wdata - write data
//   rdata - read data, valid the cycle after a read access, held until the next read
// Contents and rdata are not reset so the array maps onto block RAM.
module hpi_sp_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/hpi_responder.sv
// Target end of the 4-register HPI bus. Stands in for the USB host-controller
// side in loopback/simulation builds: word RAM behind an auto-incrementing
// byte address, a bidirectional mailbox with host interrupt, and STATUS.
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   hpi_address           - register select (DATA, MAILBOX, ADDRESS, STATUS)
//   hpi_cs_n/r_n/w_n      - active-low chip select / read / write strobes
//   hpi_data_in/out       - bus write data / read data (read data lags the access by 1 cycle)
//   hpi_int               - high while the device-to-host mailbox is full
//   dev_mbx_wdata/wr      - device loads the device-to-host word
//   dev_mbx_rdata/valid   - last host-written mailbox word and its pending flag
//   dev_mbx_ack           - device consumes the pending host word
// Bus inputs are assumed already synchronous to Clk.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter  int DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  hpi_address,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_int,
  input  logic [15:0] dev_mbx_wdata,
  input  logic        dev_mbx_wr,
  output logic [15:0] dev_mbx_rdata,
  output logic        dev_mbx_valid,
  input  logic        dev_mbx_ack
);

  logic        rd_act, wr_act, illegal;
  logic        prev_act;
  logic        acc_rd, acc_wr, acc_data;
  logic [15:0] addr_reg;
  logic [15:0] out_word;
  logic        out_full;
  logic        mbx_valid;
  logic [15:0] mbx_rdata;
  logic        ovr, err;
  logic [15:0] rd_q;     // read data for the non-RAM registers
  logic        rd_ram;   // last read targeted DATA: present the RAM output
  logic [15:0] ram_q;
  logic        ram_en;

  assign rd_act  = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
  assign wr_act  = !hpi_cs_n && !hpi_w_n &&  hpi_r_n;
  assign illegal = !hpi_cs_n && !hpi_r_n && !hpi_w_n;

  // An access fires only on the rising edge of the combined strobe.
  assign acc_rd   = rd_act && !prev_act;
  assign acc_wr   = wr_act && !prev_act;
  assign acc_data = (acc_rd || acc_wr) && (hpi_address == HPI_DATA);
  assign ram_en   = !Reset && acc_data;

  hpi_sp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (Clk),
    .en    (ram_en),
    .we    (acc_wr),
    .addr  (addr_reg[AW:1]),
    .wdata (hpi_data_in),
    .rdata (ram_q)
  );

  // Both mux inputs are registers, so the output is effectively registered
  // and holds until the next read access changes either of them.
  assign hpi_data_out  = rd_ram ? ram_q : rd_q;
  assign hpi_int       = out_full;
  assign dev_mbx_valid = mbx_valid;
  assign dev_mbx_rdata = mbx_rdata;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // prev_act=1 masks a strobe still held across reset release
      prev_act  <= 1'b1;
      rd_q      <= '0;
      rd_ram    <= 1'b0;
      addr_reg  <= '0;
      out_word  <= '0;
      out_full  <= 1'b0;
      mbx_rdata <= '0;
      mbx_valid <= 1'b0;
      ovr       <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev_act <= rd_act || wr_act;

      if (illegal)     err       <= 1'b1;
      if (dev_mbx_ack) mbx_valid <= 1'b0;
      if (dev_mbx_wr) begin
        out_word <= dev_mbx_wdata;
        out_full <= 1'b1;
      end

      if (acc_rd) begin
        rd_ram <= (hpi_address == HPI_DATA);
        case (hpi_address)
          HPI_MAILBOX: begin
            rd_q <= out_word;
            // a same-cycle device load wins: the new word stays pending
            if (!dev_mbx_wr) out_full <= 1'b0;
          end
          HPI_ADDRESS: rd_q <= addr_reg;
          HPI_STATUS:  rd_q <= status_word(err, ovr, mbx_valid, out_full);
          default: ;
        endcase
      end

      if (acc_wr) begin
        case (hpi_address)
          HPI_MAILBOX: begin
            mbx_rdata <= hpi_data_in;
            mbx_valid <= 1'b1;
            // a same-cycle ack consumed the old word, so this is no overrun
            if (mbx_valid && !dev_mbx_ack) ovr <= 1'b1;
          end
          HPI_ADDRESS: addr_reg <= {hpi_data_in[15:1], 1'b0};
          HPI_STATUS: begin
            if (hpi_data_in[ST_OVR]) ovr <= 1'b0;
            if (hpi_data_in[ST_ERR]) err <= 1'b0;
          end
          default: ;
        endcase
      end

      if (acc_data) addr_reg <= addr_reg + 16'd2;
    end
  end

endmodule

// File: tb/tb_hpi_responder.sv
module tb_hpi_responder;
  import hpi_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  hpi_address;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_int;
  logic [15:0] dev_mbx_wdata;
  logic        dev_mbx_wr;
  logic [15:0] dev_mbx_rdata;
  logic        dev_mbx_valid;
  logic        dev_mbx_ack;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  hpi_responder #(.DEPTH(4096)) dut (
    .Clk(Clk), .Reset(Reset), .hpi_address(hpi_address),
    .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
    .hpi_data_in(hpi_data_in), .hpi_data_out(hpi_data_out), .hpi_int(hpi_int),
    .dev_mbx_wdata(dev_mbx_wdata), .dev_mbx_wr(dev_mbx_wr),
    .dev_mbx_rdata(dev_mbx_rdata), .dev_mbx_valid(dev_mbx_valid),
    .dev_mbx_ack(dev_mbx_ack)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // All drives happen 1 time unit after a rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [15:0] d);
    tick();
    hpi_address = a; hpi_data_in = d; hpi_cs_n = 0; hpi_w_n = 0;
    tick(2);
    hpi_cs_n = 1; hpi_w_n = 1;
    tick();
  endtask

  task automatic host_rd(input logic [1:0] a, input int hold, output logic [15:0] d);
    tick();
    hpi_address = a; hpi_cs_n = 0; hpi_r_n = 0;
    tick(hold);
    hpi_cs_n = 1; hpi_r_n = 1;
    tick();
    d = hpi_data_out;
  endtask

  // Scoreboard read: expectation queued at issue, popped when data returns.
  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] expv);
    logic [15:0] obs;
    exp_q.push_back(expv);
    host_rd(a, 2, obs);
    check(tag, obs, exp_q.pop_front());
  endtask

  initial begin
    logic [15:0] obs;
    Reset = 1; hpi_address = 0; hpi_cs_n = 1; hpi_r_n = 1; hpi_w_n = 1;
    hpi_data_in = 0; dev_mbx_wdata = 0; dev_mbx_wr = 0; dev_mbx_ack = 0;
    tick(3);
    Reset = 0;
    tick();

    // reset state
    check("rst_data_out", hpi_data_out, 16'h0000);
    check("rst_int", {15'd0, hpi_int}, 16'h0000);
    check("rst_valid", {15'd0, dev_mbx_valid}, 16'h0000);
    check("rst_rdata", dev_mbx_rdata, 16'h0000);
    rd_chk("rst_addr", HPI_ADDRESS, 16'h0000);
    rd_chk("rst_status", HPI_STATUS, 16'h0000);

    // auto-increment writes/reads
    host_wr(HPI_ADDRESS, 16'h0100);
    host_wr(HPI_DATA, 16'hAAAA);
    host_wr(HPI_DATA, 16'h5555);
    rd_chk("addr_after_wr", HPI_ADDRESS, 16'h0104);
    host_wr(HPI_ADDRESS, 16'h0101); // bit0 forced low
    rd_chk("addr_bit0", HPI_ADDRESS, 16'h0100);
    rd_chk("data_rd0", HPI_DATA, 16'hAAAA);
    rd_chk("data_rd1", HPI_DATA, 16'h5555);

    // wrap and aliasing
    host_wr(HPI_ADDRESS, 16'hFFFE);
    host_wr(HPI_DATA, 16'h1234);
    rd_chk("addr_wrap", HPI_ADDRESS, 16'h0000);
    host_wr(HPI_ADDRESS, 16'h1FFE);
    rd_chk("alias_rd", HPI_DATA, 16'h1234);

    // host-to-device mailbox
    host_wr(HPI_MAILBOX, 16'hBEEF);
    check("h2d_valid", {15'd0, dev_mbx_valid}, 16'h0001);
    check("h2d_rdata", dev_mbx_rdata, 16'hBEEF);
    rd_chk("h2d_status", HPI_STATUS, 16'h0002);
    host_wr(HPI_MAILBOX, 16'hCAFE);
    check("h2d_rdata2", dev_mbx_rdata, 16'hCAFE);
    rd_chk("h2d_ovr", HPI_STATUS, 16'h0006);
    dev_mbx_ack = 1; tick(); dev_mbx_ack = 0;
    check("h2d_ack", {15'd0, dev_mbx_valid}, 16'h0000);
    host_wr(HPI_STATUS, 16'h0004);
    rd_chk("h2d_w1c", HPI_STATUS, 16'h0000);

    // write coinciding with ack: no overrun
    host_wr(HPI_MAILBOX, 16'h0A0A);
    tick();
    hpi_address = HPI_MAILBOX; hpi_data_in = 16'h0B0B; hpi_cs_n = 0; hpi_w_n = 0;
    dev_mbx_ack = 1;
    tick();
    dev_mbx_ack = 0;
    tick();
    hpi_cs_n = 1; hpi_w_n = 1;
    tick();
    check("ack_wr_valid", {15'd0, dev_mbx_valid}, 16'h0001);
    check("ack_wr_rdata", dev_mbx_rdata, 16'h0B0B);
    rd_chk("ack_wr_status", HPI_STATUS, 16'h0002);
    dev_mbx_ack = 1; tick(); dev_mbx_ack = 0;

    // device-to-host mailbox
    dev_mbx_wdata = 16'h0F0F; dev_mbx_wr = 1; tick(); dev_mbx_wr = 0;
    check("d2h_int", {15'd0, hpi_int}, 16'h0001);
    rd_chk("d2h_rd", HPI_MAILBOX, 16'h0F0F);
    check("d2h_int_clr", {15'd0, hpi_int}, 16'h0000);
    dev_mbx_wdata = 16'h2222; dev_mbx_wr = 1; tick(); dev_mbx_wr = 0;
    // device load in the very cycle the host read fires
    tick();
    exp_q.push_back(16'h2222);
    hpi_address = HPI_MAILBOX; hpi_cs_n = 0; hpi_r_n = 0;
    dev_mbx_wdata = 16'h1111; dev_mbx_wr = 1;
    tick();
    dev_mbx_wr = 0;
    tick();
    hpi_cs_n = 1; hpi_r_n = 1;
    tick();
    check("d2h_race_rd", hpi_data_out, exp_q.pop_front());
    check("d2h_race_int", {15'd0, hpi_int}, 16'h0001);
    rd_chk("d2h_new_word", HPI_MAILBOX, 16'h1111);
    check("d2h_int_clr2", {15'd0, hpi_int}, 16'h0000);

    // strobe held 10 cycles executes once
    host_wr(HPI_ADDRESS, 16'h0010);
    host_wr(HPI_DATA, 16'h7777);
    host_wr(HPI_ADDRESS, 16'h0010);
    exp_q.push_back(16'h7777);
    host_rd(HPI_DATA, 10, obs);
    check("hold_rd", obs, exp_q.pop_front());
    rd_chk("hold_addr", HPI_ADDRESS, 16'h0012);

    // illegal access
    tick();
    hpi_address = HPI_DATA; hpi_data_in = 16'hDEAD;
    hpi_cs_n = 0; hpi_r_n = 0; hpi_w_n = 0;
    tick(2);
    hpi_cs_n = 1; hpi_r_n = 1; hpi_w_n = 1;
    tick();
    rd_chk("ill_addr", HPI_ADDRESS, 16'h0012);
    rd_chk("ill_status", HPI_STATUS, 16'h0008);
    host_wr(HPI_ADDRESS, 16'h0010);
    rd_chk("ill_ram", HPI_DATA, 16'h7777);
    host_wr(HPI_STATUS, 16'h0008);
    rd_chk("ill_w1c", HPI_STATUS, 16'h0000);

    // reset during a held write strobe
    host_wr(HPI_ADDRESS, 16'h0000);
    host_wr(HPI_DATA, 16'h5A5A);
    tick();
    Reset = 1;
    tick();
    hpi_address = HPI_DATA; hpi_data_in = 16'h9999; hpi_cs_n = 0; hpi_w_n = 0;
    tick(2);
    Reset = 0;
    tick(3);
    hpi_cs_n = 1; hpi_w_n = 1;
    tick();
    rd_chk("rstw_addr", HPI_ADDRESS, 16'h0000);
    rd_chk("rstw_ram", HPI_DATA, 16'h5A5A);
    host_wr(HPI_ADDRESS, 16'h0000);
    host_wr(HPI_DATA, 16'h4321);
    rd_chk("rstw_once", HPI_ADDRESS, 16'h0002);
    host_wr(HPI_ADDRESS, 16'h0000);
    rd_chk("rstw_ram2", HPI_DATA, 16'h4321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
